// File: rtl/filtro_biquad_param.sv
// Runtime-programmable biquad IIR section with two coefficient banks.
// Latency: 6 cycles from capture edge to valid Yk; one sample every 7 cycles at most.
// Backpressure: none; Bandera_ADC while Ocupado=1 is dropped, coefficient writes while busy are dropped.
//
// Ports:
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   Uk, Bandera_ADC   input sample and its valid strobe
//   Modo              coefficient bank applied to the sample being captured
//   Coef_WE/Banco/Addr/Data  coefficient write port (0=b0 1=b1 2=b2 3=a1 4=a2)
//   Yk, Bandera_Listo filtered output (held) and its one-cycle update pulse
//   Ocupado           high while a sample is in flight
module filtro_biquad_param #(
   parameter int N = 25,
   parameter int F = 10
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic signed [N-1:0] Uk,
   input  logic                Bandera_ADC,
   input  logic                Modo,
   input  logic                Coef_WE,
   input  logic                Coef_Banco,
   input  logic [2:0]          Coef_Addr,
   input  logic signed [N-1:0] Coef_Data,
   output logic signed [N-1:0] Yk,
   output logic                Bandera_Listo,
   output logic                Ocupado
);

   localparam int PW = 2 * N;
   localparam int AW = 2 * N + 3;
   localparam logic signed [N-1:0]  ONE_Q = N'(1) <<< F;
   localparam logic signed [AW-1:0] HALF  = AW'(1) <<< (F - 1);

   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

   state_t              state;
   logic signed [N-1:0] coef [2][5];
   // Working copy of the selected bank, taken at capture so that later
   // writes or Modo changes cannot disturb the sample in flight.
   logic signed [N-1:0] cw [5];
   logic signed [N-1:0] x0, x1, x2, y1, y2;
   logic signed [AW-1:0] acc;
   logic [2:0]          idx;

   logic signed [N-1:0]  coef_sel, opd;
   logic signed [PW-1:0] coef_ext, opd_ext, prod;
   logic signed [AW-1:0] prod_ext, rnd, shifted;
   logic signed [N-1:0]  y_sat;

   always_comb begin
      coef_sel = cw[0];
      opd      = x0;
      unique case (idx)
         3'd0:    begin coef_sel = cw[0]; opd = x0; end
         3'd1:    begin coef_sel = cw[1]; opd = x1; end
         3'd2:    begin coef_sel = cw[2]; opd = x2; end
         3'd3:    begin coef_sel = cw[3]; opd = y1; end
         3'd4:    begin coef_sel = cw[4]; opd = y2; end
         default: begin coef_sel = cw[0]; opd = x0; end
      endcase
   end

   // Single shared multiplier; signed size casts sign-extend to 2N.
   assign coef_ext = PW'(coef_sel);
   assign opd_ext  = PW'(opd);
   assign prod     = coef_ext * opd_ext;
   assign prod_ext = AW'(prod);

   // Round half up, then clamp: in range iff all bits from N-1 upward agree.
   assign rnd     = acc + HALF;
   assign shifted = rnd >>> F;

   always_comb begin
      y_sat = shifted[N-1:0];
      if (!((&shifted[AW-1:N-1]) || !(|shifted[AW-1:N-1]))) begin
         y_sat = shifted[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         Yk            <= '0;
         Bandera_Listo <= 1'b0;
         Ocupado       <= 1'b0;
         acc           <= '0;
         idx           <= '0;
         x0            <= '0;
         x1            <= '0;
         x2            <= '0;
         y1            <= '0;
         y2            <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 5; i++) begin
               coef[b][i] <= (i == 0) ? ONE_Q : '0;
            end
         end
         for (int i = 0; i < 5; i++) begin
            cw[i] <= '0;
         end
      end else begin
         Bandera_Listo <= 1'b0;

         if (Coef_WE && (state == IDLE) && (Coef_Addr < 3'd5)) begin
            coef[Coef_Banco][Coef_Addr] <= Coef_Data;
         end

         unique case (state)
            IDLE: begin
               if (Bandera_ADC) begin
                  x0      <= Uk;
                  acc     <= '0;
                  idx     <= '0;
                  Ocupado <= 1'b1;
                  state   <= MAC;
                  // Nonblocking read: a same-edge write is not yet visible here.
                  for (int i = 0; i < 5; i++) begin
                     cw[i] <= coef[Modo][i];
                  end
               end
            end
            MAC: begin
               // Feedback terms carry a1/a2 as stored, so they are subtracted.
               if (idx >= 3'd3) begin
                  acc <= acc - prod_ext;
               end else begin
                  acc <= acc + prod_ext;
               end
               if (idx == 3'd4) begin
                  state <= SAT;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            SAT: begin
               Yk            <= y_sat;
               x2            <= x1;
               x1            <= x0;
               y2            <= y1;
               y1            <= y_sat;
               Bandera_Listo <= 1'b1;
               Ocupado       <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filtro_biquad_param.sv
module tb_filtro_biquad_param;

   typedef logic signed [63:0] v64_t;

   logic               Clk = 1'b0;
   logic               Reset = 1'b1;
   logic signed [24:0] Uk = '0;
   logic               Bandera_ADC = 1'b0;
   logic               Modo = 1'b0;
   logic               Coef_WE = 1'b0;
   logic               Coef_Banco = 1'b0;
   logic [2:0]         Coef_Addr = '0;
   logic signed [24:0] Coef_Data = '0;
   logic signed [24:0] Yk;
   logic               Bandera_Listo;
   logic               Ocupado;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: plain integers, difference equation evaluated directly.
   longint mc [2][5];
   longint mx1, mx2, my1, my2;

   filtro_biquad_param #(.N(25), .F(10)) dut (
      .Clk(Clk), .Reset(Reset), .Uk(Uk), .Bandera_ADC(Bandera_ADC), .Modo(Modo),
      .Coef_WE(Coef_WE), .Coef_Banco(Coef_Banco), .Coef_Addr(Coef_Addr),
      .Coef_Data(Coef_Data), .Yk(Yk), .Bandera_Listo(Bandera_Listo), .Ocupado(Ocupado)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input v64_t obs, input v64_t exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 5; i++)
            mc[b][i] = (i == 0) ? 64'sd1024 : 64'sd0;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
   endtask

   function automatic longint model_step(input longint u, input int m);
      longint acc, y;
      acc = mc[m][0] * u + mc[m][1] * mx1 + mc[m][2] * mx2 - mc[m][3] * my1 - mc[m][4] * my2;
      y = (acc + 512) >>> 10;
      if (y > 16777215) y = 16777215;
      if (y < -16777216) y = -16777216;
      mx2 = mx1; mx1 = u; my2 = my1; my1 = y;
      return y;
   endfunction

   task automatic do_reset();
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk); Reset = 1'b0;
      model_reset();
   endtask

   task automatic wr_coef(input logic b, input logic [2:0] a, input logic signed [24:0] d);
      @(negedge Clk);
      Coef_WE = 1'b1; Coef_Banco = b; Coef_Addr = a; Coef_Data = d;
      @(negedge Clk);
      Coef_WE = 1'b0;
      if (a < 3'd5) mc[b][a] = longint'(d);
   endtask

   // One full sample: capture, optional same-edge coefficient write, then
   // latency / busy-length / value / pulse-width checks.
   task automatic run_sample(input logic signed [24:0] u, input logic m, input bit use_exp,
                             input longint exp_v, input string tag, input bit wr,
                             input logic wb, input logic [2:0] wa, input logic signed [24:0] wd);
      longint y_ref;
      int k, busy;
      @(negedge Clk);
      Uk = u; Modo = m; Bandera_ADC = 1'b1;
      Coef_WE = wr; Coef_Banco = wb; Coef_Addr = wa; Coef_Data = wd;
      @(negedge Clk);
      Bandera_ADC = 1'b0; Coef_WE = 1'b0; Modo = ~m;
      y_ref = model_step(longint'(u), int'(m));
      if (wr && wa < 3'd5) mc[wb][wa] = longint'(wd);
      k = 0; busy = 0;
      while (!Bandera_Listo && k < 20) begin
         if (Ocupado) busy++;
         @(negedge Clk);
         k++;
      end
      chk({tag, "_latency"}, k, 6);
      chk({tag, "_busy_cycles"}, busy, 6);
      chk({tag, "_yk"}, $signed(Yk), use_exp ? exp_v : y_ref);
      chk({tag, "_busy_at_listo"}, Ocupado, 0);
      @(negedge Clk);
      chk({tag, "_listo_width"}, Bandera_Listo, 0);
   endtask

   task automatic samp(input logic signed [24:0] u, input logic m, input longint exp_v, input string tag);
      run_sample(u, m, 1'b1, exp_v, tag, 1'b0, 1'b0, 3'd0, '0);
   endtask

   initial begin
      int pulses;
      logic signed [24:0] ybusy, ru, rd;
      model_reset();

      // Reset state
      @(negedge Clk);
      chk("rst_yk", $signed(Yk), 0);
      chk("rst_listo", Bandera_Listo, 0);
      chk("rst_busy", Ocupado, 0);
      Reset = 1'b0;

      // Pass-through after reset
      samp(25'sd300, 1'b0, 300, "pass1");
      samp(-25'sd77, 1'b0, -77, "pass2");

      // Two-tap average on bank 0
      do_reset();
      wr_coef(1'b0, 3'd0, 25'sd512);
      wr_coef(1'b0, 3'd1, 25'sd512);
      samp(25'sd1000, 1'b0, 500, "avg1");
      samp(25'sd2000, 1'b0, 1500, "avg2");
      samp(25'sd2000, 1'b0, 2000, "avg3");

      // Recursion and rounding on bank 1
      do_reset();
      wr_coef(1'b1, 3'd0, 25'sd1024);
      wr_coef(1'b1, 3'd3, -25'sd512);
      samp(25'sd1000, 1'b1, 1000, "rec1");
      samp(25'sd0, 1'b1, 500, "rec2");
      samp(25'sd0, 1'b1, 250, "rec3");
      samp(25'sd0, 1'b1, 125, "rec4");
      samp(25'sd0, 1'b1, 63, "rec5_round");

      // Saturation both directions
      do_reset();
      wr_coef(1'b0, 3'd0, 25'sd2048);
      samp(25'sd8388608, 1'b0, 16777215, "sat_pos");
      samp(-25'sd9000000, 1'b0, -16777216, "sat_neg");

      // Busy rules within one computation
      do_reset();
      wr_coef(1'b1, 3'd0, 25'sd2048);
      @(negedge Clk); Uk = 25'sd500; Modo = 1'b0; Bandera_ADC = 1'b1;
      @(negedge Clk); Bandera_ADC = 1'b0;                       // after E0
      @(negedge Clk);                                           // after E1
      Coef_WE = 1'b1; Coef_Banco = 1'b0; Coef_Addr = 3'd0; Coef_Data = 25'sd2048; Modo = 1'b1;
      @(negedge Clk);                                           // after E2
      Coef_WE = 1'b0; Uk = 25'sd7777; Bandera_ADC = 1'b1;
      @(negedge Clk); Bandera_ADC = 1'b0;                       // after E3
      pulses = 0; ybusy = '0;
      for (int i = 0; i < 15; i++) begin
         if (Bandera_Listo) begin pulses++; ybusy = Yk; end
         @(negedge Clk);
      end
      chk("busy_one_pulse", pulses, 1);
      chk("busy_yk", $signed(ybusy), model_step(500, 0));
      run_sample(25'sd100, 1'b0, 1'b0, 0, "busy_after", 1'b0, 1'b0, 3'd0, '0);

      // Mid-operation reset
      do_reset();
      wr_coef(1'b0, 3'd0, 25'sd2048);
      samp(25'sd300, 1'b0, 600, "pre_reset");
      @(negedge Clk); Uk = 25'sd1234; Bandera_ADC = 1'b1;
      @(negedge Clk); Bandera_ADC = 1'b0;                       // after E0
      @(negedge Clk);                                           // after E1
      @(negedge Clk);                                           // after E2
      Reset = 1'b1;
      #1;
      chk("midrst_yk", $signed(Yk), 0);
      chk("midrst_busy", Ocupado, 0);
      @(negedge Clk); Reset = 1'b0;
      model_reset();
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (Bandera_Listo) pulses++;
         @(negedge Clk);
      end
      chk("midrst_no_listo", pulses, 0);
      samp(25'sd300, 1'b0, 300, "post_reset");

      // Simultaneous capture and write: sample uses the old b0
      run_sample(25'sd400, 1'b0, 1'b1, 400, "same_edge_wr", 1'b1, 1'b0, 3'd0, 25'sd2048);
      samp(25'sd400, 1'b0, 800, "same_edge_after");

      // Randomized coefficients and samples against the reference model
      do_reset();
      for (int i = 0; i < 12; i++) begin
         rd = 25'(int'($urandom_range(0, 4096)) - 2048);
         wr_coef(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rd);
      end
      for (int i = 0; i < 20; i++) begin
         ru = ($urandom_range(0, 1) == 1) ? 25'($urandom) : 25'(int'($urandom_range(0, 20000)) - 10000);
         rd = 25'(int'($urandom_range(0, 4096)) - 2048);
         run_sample(ru, 1'($urandom_range(0, 1)), 1'b0, 0, $sformatf("rnd%0d", i),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
